// File: rtl/pio_cmd_pkg.sv
// Shared definitions for the HPS-to-fabric PIO command responder.
// Holds the opcode and FSM state encodings, the pio_status bit positions
// and the bit layout of the 29-bit instruction word.
package pio_cmd_pkg;

  // Instruction word layout: [2:0] opcode, [19:3] addr, [27:20] data, [28] reserved.
  localparam int unsigned INSTR_W  = 29;
  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned OP_MSB   = 2;
  localparam int unsigned ADDR_LSB = 3;
  localparam int unsigned ADDR_MSB = 19;
  localparam int unsigned DATA_LSB = 20;
  localparam int unsigned DATA_MSB = 27;
  localparam int unsigned RSVD_BIT = 28;

  // pio_status bit positions.
  localparam int unsigned ST_ERR  = 3;
  localparam int unsigned ST_DONE = 2;
  localparam int unsigned ST_MAX  = 1;
  localparam int unsigned ST_MIN  = 0;

  typedef enum logic [2:0] {
    OpNop     = 3'd0,
    OpLoad    = 3'd1,
    OpStore   = 3'd2,
    OpZoomIn  = 3'd3,
    OpZoomOut = 3'd4,
    OpZoomRst = 3'd5,
    OpIll6    = 3'd6,
    OpIll7    = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecode = 3'd1,
    StIssue  = 3'd2,
    StWait   = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/pio_cmd_decode.sv
// Combinational decoder for a latched PIO instruction.
// Extracts opcode/addr/data, checks legality (opcode range, LOAD/STORE
// address range, zoom saturation) and computes the zoom level that a
// local op would leave behind.
// Ports:
//   instr_i    - latched instruction word, reserved bit stripped
//   zoom_i     - current zoom level
//   op_o       - opcode field
//   addr_o     - address field
//   data_o     - data field
//   zoom_o     - zoom level after executing the op (== zoom_i unless a legal zoom op)
//   is_local_o - op completes without the pixel engine (includes all rejected ops)
//   err_o      - op is illegal
module pio_cmd_decode
  import pio_cmd_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 3,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_LIMIT = 76800,
  parameter int unsigned ZOOM_MAX   = 3,
  localparam int unsigned ZOOM_W    = $clog2(ZOOM_MAX + 1)
) (
  input  logic [DATA_MSB:0]   instr_i,
  input  logic [ZOOM_W-1:0]   zoom_i,
  output logic [OPCODE_W-1:0] op_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [ZOOM_W-1:0]   zoom_o,
  output logic                is_local_o,
  output logic                err_o
);

  opcode_e op;

  assign op_o   = instr_i[OP_MSB:OP_LSB];
  assign addr_o = instr_i[ADDR_MSB:ADDR_LSB];
  assign data_o = instr_i[DATA_MSB:DATA_LSB];
  assign op     = opcode_e'(op_o);

  always_comb begin
    zoom_o     = zoom_i;
    is_local_o = 1'b1;
    err_o      = 1'b0;
    unique case (op)
      OpNop: ;
      OpLoad, OpStore: begin
        // Out-of-frame accesses are rejected here and never reach the engine.
        if (32'(addr_o) >= ADDR_LIMIT) begin
          err_o = 1'b1;
        end else begin
          is_local_o = 1'b0;
        end
      end
      OpZoomIn: begin
        if (zoom_i == ZOOM_W'(ZOOM_MAX)) err_o = 1'b1;
        else                              zoom_o = zoom_i + 1'b1;
      end
      OpZoomOut: begin
        if (zoom_i == '0) err_o = 1'b1;
        else              zoom_o = zoom_i - 1'b1;
      end
      OpZoomRst: zoom_o = '0;
      default:   err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/pio_cmd_responder.sv
// FPGA-side responder for the HPS-to-fabric PIO command channel.
// Captures an instruction on a rising edge of start, decodes it, executes
// zoom ops locally and dispatches LOAD/STORE to the pixel engine over a
// valid/ready channel, then reports done/error/zoom limits to the HPS.
// Optional engine watchdog: define PIO_CMD_TIMEOUT_EN.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   pio_instruction     - instruction word from the HPS
//   pio_control         - [0] start (level), [1] clear
//   pio_status          - [3] error, [2] done, [1] zoom_max, [0] zoom_min
//   cmd_valid/cmd_ready - command handshake to the pixel engine
//   cmd_op/addr/data    - command fields, stable while cmd_valid is high
//   cmd_zoom            - current zoom level
//   rsp_valid/rsp_error - engine completion pulse and its error flag
module pio_cmd_responder
  import pio_cmd_pkg::*;
#(
  parameter int unsigned OPCODE_W       = 3,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_LIMIT     = 76800,
  parameter int unsigned ZOOM_MAX       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned ZOOM_W        = $clog2(ZOOM_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [INSTR_W-1:0]  pio_instruction,
  input  logic [1:0]          pio_control,
  output logic [3:0]          pio_status,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [OPCODE_W-1:0] cmd_op,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [DATA_W-1:0]   cmd_data,
  output logic [ZOOM_W-1:0]   cmd_zoom,
  input  logic                rsp_valid,
  input  logic                rsp_error
);

  state_e            state_q, state_d;
  logic              start_q;
  logic [DATA_MSB:0] instr_q, instr_d;
  logic [ZOOM_W-1:0] zoom_q, zoom_d;
  logic              err_q, err_d;

  logic              start, clear, start_edge;
  logic              timeout_hit;
  logic [ZOOM_W-1:0] dec_zoom;
  logic              dec_is_local, dec_err;

  // The reserved instruction bit carries no meaning.
  logic unused_rsvd;
  assign unused_rsvd = pio_instruction[RSVD_BIT];

  assign start      = pio_control[0];
  assign clear      = pio_control[1];
  assign start_edge = start & ~start_q;

  pio_cmd_decode #(
    .OPCODE_W  (OPCODE_W),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ADDR_LIMIT(ADDR_LIMIT),
    .ZOOM_MAX  (ZOOM_MAX)
  ) u_decode (
    .instr_i   (instr_q),
    .zoom_i    (zoom_q),
    .op_o      (cmd_op),
    .addr_o    (cmd_addr),
    .data_o    (cmd_data),
    .zoom_o    (dec_zoom),
    .is_local_o(dec_is_local),
    .err_o     (dec_err)
  );

`ifdef PIO_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StDecode) begin
      tmo_d = '0;
    end else if (state_q == StIssue || state_q == StWait) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  // tmo_q counts cycles already spent in ISSUE/WAIT; fire during the last allowed one.
  assign timeout_hit = (state_q == StIssue || state_q == StWait) &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_edge) state_d = StDecode;
      StDecode: state_d = dec_is_local ? StDone : StIssue;
      StIssue:  if (cmd_ready) state_d = StWait;
      StWait:   if (rsp_valid) state_d = StDone;
      StDone:   if (!start) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (timeout_hit) state_d = StDone;
    if (clear)       state_d = StIdle;
  end

  // Outputs. Clear and timeout withdraw cmd_valid in the same cycle so the
  // engine never accepts a command the responder is abandoning.
  always_comb begin
    cmd_valid           = (state_q == StIssue) && !clear && !timeout_hit;
    pio_status          = '0;
    pio_status[ST_ERR]  = err_q;
    pio_status[ST_DONE] = (state_q == StDone);
    pio_status[ST_MAX]  = (zoom_q == ZOOM_W'(ZOOM_MAX));
    pio_status[ST_MIN]  = (zoom_q == '0);
    cmd_zoom            = zoom_q;
  end

  // Datapath next-state: instruction latch, zoom level, sticky error.
  always_comb begin
    instr_d = instr_q;
    zoom_d  = zoom_q;
    err_d   = err_q;
    if (state_q == StIdle && start_edge) begin
      instr_d = pio_instruction[DATA_MSB:0];
      err_d   = 1'b0;
    end
    if (state_q == StDecode) begin
      zoom_d = dec_zoom;
      err_d  = dec_err;
    end
    if (state_q == StWait && rsp_valid) err_d = rsp_error;
    if (timeout_hit) err_d = 1'b1;
    if (clear) begin
      instr_d = instr_q;
      zoom_d  = zoom_q;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      instr_q <= '0;
      zoom_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // start_q tracks start even during clear so a held start cannot retrigger.
      start_q <= start;
      instr_q <= instr_d;
      zoom_q  <= zoom_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pio_cmd_responder.sv
module tb_pio_cmd_responder;

  logic        clk;
  logic        reset_n;
  logic [28:0] pio_instruction;
  logic [1:0]  pio_control;
  logic [3:0]  pio_status;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [1:0]  cmd_zoom;
  logic        rsp_valid;
  logic        rsp_error;

  int n_checks = 0;
  int n_errors = 0;

  pio_cmd_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_instruction(pio_instruction),
    .pio_control    (pio_control),
    .pio_status     (pio_status),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .cmd_zoom       (cmd_zoom),
    .rsp_valid      (rsp_valid),
    .rsp_error      (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [28:0] mk(input logic [2:0] op, input logic [16:0] addr,
                                     input logic [7:0] data);
    return {1'b0, data, addr, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake for an op that completes without the engine.
  task automatic run_local(input string tag, input logic [28:0] instr,
                           input logic [3:0] exp_status, input logic [1:0] exp_zoom);
    pio_instruction = instr;
    pio_control     = 2'b01;
    tick();
    check({tag, " decode cmd_valid"}, 32'(cmd_valid), 32'd0);
    tick();
    check({tag, " status"}, 32'(pio_status), 32'(exp_status));
    check({tag, " zoom"}, 32'(cmd_zoom), 32'(exp_zoom));
    check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd0);
    pio_control = 2'b00;
    tick();
    check({tag, " release"}, 32'(pio_status), 32'(exp_status & 4'b1011));
  endtask

  // LOAD/STORE through the engine: ready after ready_dly idle cycles,
  // response rsp_dly cycles after the handshake.
  task automatic run_engine(input string tag, input logic [2:0] op, input logic [16:0] addr,
                            input logic [7:0] data, input int ready_dly, input int rsp_dly,
                            input logic err, input logic [3:0] exp_status);
    pio_instruction = mk(op, addr, data);
    pio_control     = 2'b01;
    tick();
    tick();
    for (int i = 0; i < ready_dly; i++) begin
      check({tag, " cmd_valid hold"}, 32'(cmd_valid), 32'd1);
      check({tag, " cmd fields hold"}, {4'd0, cmd_data, cmd_addr, cmd_op}, {4'd0, data, addr, op});
      tick();
    end
    check({tag, " cmd_valid"}, 32'(cmd_valid), 32'd1);
    check({tag, " cmd fields"}, {4'd0, cmd_data, cmd_addr, cmd_op}, {4'd0, data, addr, op});
    check({tag, " issue status"}, 32'(pio_status), 32'(exp_status & 4'b0011));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({tag, " wait cmd_valid"}, 32'(cmd_valid), 32'd0);
    for (int i = 1; i < rsp_dly; i++) begin
      check({tag, " wait done"}, 32'(pio_status[2]), 32'd0);
      tick();
    end
    rsp_valid = 1'b1;
    rsp_error = err;
    tick();
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    check({tag, " status"}, 32'(pio_status), 32'(exp_status));
    pio_control = 2'b00;
    tick();
    check({tag, " release"}, 32'(pio_status), 32'(exp_status & 4'b1011));
  endtask

  initial begin
    reset_n         = 1'b0;
    pio_instruction = '0;
    pio_control     = 2'b00;
    cmd_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_error       = 1'b0;
    tick();
    tick();
    check("reset status", 32'(pio_status), 32'h1);
    check("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset cmd fields", {4'd0, cmd_data, cmd_addr, cmd_op}, 32'd0);
    check("reset zoom", 32'(cmd_zoom), 32'd0);
    reset_n = 1'b1;
    tick();

    // Zoom in to the top, then saturate.
    run_local("zoom_in 1", mk(3'd3, 17'd0, 8'd0), 4'b0100, 2'd1);
    run_local("zoom_in 2", mk(3'd3, 17'd0, 8'd0), 4'b0100, 2'd2);
    run_local("zoom_in 3", mk(3'd3, 17'd0, 8'd0), 4'b0110, 2'd3);
    run_local("zoom_in sat", mk(3'd3, 17'd0, 8'd0), 4'b1110, 2'd3);
    run_local("nop", mk(3'd0, 17'd0, 8'd0), 4'b0110, 2'd3);
    run_local("zoom_out", mk(3'd4, 17'd0, 8'd0), 4'b0100, 2'd2);
    run_local("zoom_rst", mk(3'd5, 17'd0, 8'd0), 4'b0101, 2'd0);
    run_local("zoom_out sat", mk(3'd4, 17'd0, 8'd0), 4'b1101, 2'd0);

    // Engine commands.
    run_engine("store ok", 3'd2, 17'd100, 8'hAB, 5, 3, 1'b0, 4'b0101);
    run_engine("store err", 3'd2, 17'd100, 8'hAB, 5, 3, 1'b1, 4'b1101);
    run_engine("load last addr", 3'd1, 17'd76799, 8'h5A, 0, 1, 1'b0, 4'b0101);

    // Rejected without dispatch.
    run_local("load oob", mk(3'd1, 17'd76800, 8'h00), 4'b1101, 2'd0);
    run_local("opcode 7", mk(3'd7, 17'd10, 8'h00), 4'b1101, 2'd0);
    run_local("opcode 6", mk(3'd6, 17'd10, 8'h00), 4'b1101, 2'd0);

    // Clear during WAIT, then a late response and a held start.
    pio_instruction = mk(3'd1, 17'd5, 8'h11);
    pio_control     = 2'b01;
    tick();
    tick();
    check("clr issue cmd_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready   = 1'b0;
    pio_control = 2'b11;
    tick();
    check("clr status", 32'(pio_status), 32'h1);
    check("clr cmd_valid", 32'(cmd_valid), 32'd0);
    pio_control = 2'b01;
    rsp_valid   = 1'b1;
    rsp_error   = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    check("late rsp ignored", 32'(pio_status), 32'h1);
    tick();
    tick();
    tick();
    check("held start cmd_valid", 32'(cmd_valid), 32'd0);
    check("held start status", 32'(pio_status), 32'h1);

    // Clear wins over a start edge in the same cycle.
    pio_control = 2'b00;
    tick();
    pio_control = 2'b11;
    tick();
    pio_control = 2'b01;
    tick();
    tick();
    check("clr+start cmd_valid", 32'(cmd_valid), 32'd0);
    check("clr+start status", 32'(pio_status), 32'h1);

    // Normal operation resumes after clear.
    pio_control = 2'b00;
    tick();
    run_local("zoom_in after clr", mk(3'd3, 17'd0, 8'd0), 4'b0100, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
